// File: rtl/tx_module_pkg.sv
// rtl/tx_module_pkg.sv - shared UART state encodings, configuration field layout and helpers
package tx_module_pkg;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_SEND_START  = 3'd1;
    localparam logic [2:0] ST_SEND_DATA   = 3'd2;
    localparam logic [2:0] ST_SEND_PARITY = 3'd3;
    localparam logic [2:0] ST_SEND_STOP   = 3'd4;

    localparam logic [3:0] SAMPLE_COUNTER_MAX = 4'd15;

    // Configuration word layout: {data[1:0], stop[1:0], parity_en}
    localparam int CONF_PARITY_BIT = 0;
    localparam int CONF_STOP_LSB   = 1;
    localparam int CONF_DATA_LSB   = 3;

    localparam int DATA_BITS_BASE = 5;

    // Selects the low 5..8 bits of a character according to the data-width field.
    function automatic logic [7:0] data_mask(input logic [1:0] data_conf);
        logic [1:0] drop;
        drop = 2'd3 - data_conf;
        return 8'hFF >> drop;
    endfunction

endpackage

// File: rtl/uart_symbol_timer.sv
// rtl/uart_symbol_timer.sv - per-symbol oversample tick counter with symbol-end strobe
module uart_symbol_timer #(
    parameter int                 WIDTH = 4,
    parameter logic [WIDTH-1:0]   MAX   = '1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic tick_i,
    output logic symbol_end_o
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (tick_i) begin
            count <= (count == MAX) ? '0 : count + 1'b1;
        end
    end

    assign symbol_end_o = tick_i && !clear_i && (count == MAX);

endmodule

// File: rtl/tx_module.sv
// rtl/tx_module.sv - UART transmit engine: start, 5-8 data bits LSB first, optional even parity, 1-4 stop bits
module tx_module
    import tx_module_pkg::*;
#(
    parameter int MAX_UART_DATA_W      = 8,
    parameter int STOP_CONF_WIDTH      = 2,
    parameter int DATA_CONF_WIDTH      = 2,
    parameter int SAMPLE_COUNTER_WIDTH = 4,
    parameter int TOTAL_CONF_WIDTH     = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        baud_en_i,
    input  logic                        tx_en_i,
    input  logic                        tx_start_i,
    input  logic [TOTAL_CONF_WIDTH-1:0] tx_conf_i,
    input  logic [MAX_UART_DATA_W-1:0]  tx_data_i,
    output logic                        uart_tx_o,
    output logic                        tx_busy_o,
    output logic                        tx_done_o
);

    localparam int CNT_W = $clog2(MAX_UART_DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT_BASE = CNT_W'(DATA_BITS_BASE - 1);

    logic [2:0]                  state;
    logic [MAX_UART_DATA_W-1:0]  data_r;
    logic [TOTAL_CONF_WIDTH-1:0] conf_r;
    logic [CNT_W-1:0]            data_cnt;
    logic [STOP_CONF_WIDTH-1:0]  stop_cnt;
    logic                        line_r;
    logic                        busy_r;
    logic                        done_r;

    logic                        in_frame;
    logic                        symbol_end;
    logic                        parity_en;
    logic [STOP_CONF_WIDTH-1:0]  stop_conf;
    logic [DATA_CONF_WIDTH-1:0]  data_conf;
    logic                        last_data;
    logic                        parity_bit;

    assign parity_en = conf_r[CONF_PARITY_BIT];
    assign stop_conf = conf_r[CONF_STOP_LSB +: STOP_CONF_WIDTH];
    assign data_conf = conf_r[CONF_DATA_LSB +: DATA_CONF_WIDTH];

    assign in_frame   = (state == ST_SEND_START) || (state == ST_SEND_DATA) ||
                        (state == ST_SEND_PARITY) || (state == ST_SEND_STOP);
    assign last_data  = (data_cnt == LAST_BIT_BASE + CNT_W'(data_conf));
    // Parity covers only the bits actually transmitted, not the dropped upper bits.
    assign parity_bit = ^(data_r & MAX_UART_DATA_W'(data_mask(data_conf)));

    uart_symbol_timer #(
        .WIDTH (SAMPLE_COUNTER_WIDTH),
        .MAX   (SAMPLE_COUNTER_MAX)
    ) u_symbol_timer (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (!in_frame),
        .tick_i       (baud_en_i && in_frame),
        .symbol_end_o (symbol_end)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ST_IDLE;
            data_r   <= '0;
            conf_r   <= '0;
            data_cnt <= '0;
            stop_cnt <= '0;
            line_r   <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    line_r <= 1'b1;
                    busy_r <= 1'b0;
                    if (tx_en_i && tx_start_i) begin
                        data_r   <= tx_data_i;
                        conf_r   <= tx_conf_i;
                        data_cnt <= '0;
                        stop_cnt <= '0;
                        busy_r   <= 1'b1;
                        line_r   <= 1'b0;
                        state    <= ST_SEND_START;
                    end
                end
                ST_SEND_START: begin
                    if (symbol_end) begin
                        line_r <= data_r[0];
                        state  <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (symbol_end) begin
                        if (!last_data) begin
                            data_cnt <= data_cnt + 1'b1;
                            line_r   <= data_r[data_cnt + 1'b1];
                        end else if (parity_en) begin
                            line_r <= parity_bit;
                            state  <= ST_SEND_PARITY;
                        end else begin
                            line_r <= 1'b1;
                            state  <= ST_SEND_STOP;
                        end
                    end
                end
                ST_SEND_PARITY: begin
                    if (symbol_end) begin
                        line_r <= 1'b1;
                        state  <= ST_SEND_STOP;
                    end
                end
                ST_SEND_STOP: begin
                    line_r <= 1'b1;
                    if (symbol_end) begin
                        if (stop_cnt == stop_conf) begin
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    line_r <= 1'b1;
                    busy_r <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign uart_tx_o = line_r;
    assign tx_busy_o = busy_r;
    assign tx_done_o = done_r;

endmodule

// File: tb/tb_tx_module.sv
// tb/tb_tx_module.sv - directed self-checking bench for the UART transmit engine
module tb_tx_module;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       baud_en_i;
    logic       tx_en_i;
    logic       tx_start_i;
    logic [4:0] tx_conf_i;
    logic [7:0] tx_data_i;
    logic       uart_tx_o;
    logic       tx_busy_o;
    logic       tx_done_o;

    int tests = 0;
    int fails = 0;
    int baud_div = 0;

    localparam logic [4:0] CONF_8N1 = 5'b11000;
    localparam logic [4:0] CONF_5E2 = 5'b00011;
    localparam logic [4:0] CONF_7E1 = 5'b10001;

    tx_module dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .baud_en_i  (baud_en_i),
        .tx_en_i    (tx_en_i),
        .tx_start_i (tx_start_i),
        .tx_conf_i  (tx_conf_i),
        .tx_data_i  (tx_data_i),
        .uart_tx_o  (uart_tx_o),
        .tx_busy_o  (tx_busy_o),
        .tx_done_o  (tx_done_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance to the next falling edge; baud_en_i set here applies to the following rising edge.
    task automatic step();
        @(negedge clk_i);
        baud_div  = (baud_div + 1) % 4;
        baud_en_i = (baud_div == 0);
    endtask

    task automatic start_frame(input string name, input logic [7:0] data, input logic [4:0] conf, input bit hold);
        tx_data_i  = data;
        tx_conf_i  = conf;
        tx_en_i    = 1'b1;
        tx_start_i = 1'b1;
        step();
        tests++;
        if (uart_tx_o !== 1'b0 || tx_busy_o !== 1'b1) begin
            fails++;
            $display("FAIL %s accept: line=%b busy=%b, want line=0 busy=1", name, uart_tx_o, tx_busy_o);
        end
        if (!hold) tx_start_i = 1'b0;
    endtask

    task automatic monitor_frame(input string name, input logic [15:0] exp, input int nsym,
                                 input bit hold, input int poke_at, input int drop_en_at);
        int ticks;
        int cyc;
        int bad_busy;
        bit done_seen;
        bit prev;
        ticks = 0; cyc = 0; bad_busy = 0; done_seen = 0;
        while (!done_seen && cyc < 3000) begin
            prev = baud_en_i;
            step();
            cyc++;
            if (cyc == poke_at + 1) tx_start_i = 1'b0;
            if (cyc == poke_at) begin
                tx_start_i = 1'b1;
                tx_data_i  = ~tx_data_i;
            end
            if (cyc == drop_en_at) tx_en_i = 1'b0;
            if (prev) ticks++;
            if (tx_done_o === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                if (tx_busy_o !== 1'b1) bad_busy++;
                if (prev && (ticks % 16) == 8) begin
                    tests++;
                    if (uart_tx_o !== exp[ticks / 16]) begin
                        fails++;
                        $display("FAIL %s symbol%0d: line=%b, want %b", name, ticks / 16, uart_tx_o, exp[ticks / 16]);
                    end
                end
            end
        end
        tests++;
        if (!done_seen || ticks != 16 * nsym) begin
            fails++;
            $display("FAIL %s length: done=%0d at tick %0d, want done at tick %0d", name, done_seen, ticks, 16 * nsym);
        end
        tests++;
        if (bad_busy != 0 || tx_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL %s busy: %0d low cycles in frame, busy at done=%b, want 0 and 0", name, bad_busy, tx_busy_o);
        end
        step();
        tests++;
        if (hold) begin
            if (tx_done_o !== 1'b0 || tx_busy_o !== 1'b1 || uart_tx_o !== 1'b0) begin
                fails++;
                $display("FAIL %s restart: done=%b busy=%b line=%b, want 0 1 0", name, tx_done_o, tx_busy_o, uart_tx_o);
            end
        end else begin
            if (tx_done_o !== 1'b0 || tx_busy_o !== 1'b0 || uart_tx_o !== 1'b1) begin
                fails++;
                $display("FAIL %s after_done: done=%b busy=%b line=%b, want 0 0 1", name, tx_done_o, tx_busy_o, uart_tx_o);
            end
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; tx_en_i = 1'b0; tx_start_i = 1'b0;
        tx_conf_i = '0; tx_data_i = '0; baud_en_i = 1'b0;
        repeat (3) step();
        tests++;
        if (uart_tx_o !== 1'b1) begin fails++; $display("FAIL reset_line: got %b want 1", uart_tx_o); end
        tests++;
        if (tx_busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", tx_busy_o); end
        tests++;
        if (tx_done_o !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", tx_done_o); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_8n1();
        start_frame("8n1_a5", 8'hA5, CONF_8N1, 1'b0);
        monitor_frame("8n1_a5", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, 1'b0, -10, -10);
    endtask

    task automatic test_5e2();
        start_frame("5e2_ff", 8'hFF, CONF_5E2, 1'b0);
        monitor_frame("5e2_ff", {7'b0, 1'b1, 1'b1, 1'b1, 5'h1F, 1'b0}, 9, 1'b0, -10, -10);
    endtask

    task automatic test_7e1();
        start_frame("7e1_03", 8'h03, CONF_7E1, 1'b0);
        monitor_frame("7e1_03", {6'b0, 1'b1, 1'b0, 7'h03, 1'b0}, 10, 1'b0, -10, -10);
        start_frame("7e1_07", 8'h07, CONF_7E1, 1'b0);
        monitor_frame("7e1_07", {6'b0, 1'b1, 1'b1, 7'h07, 1'b0}, 10, 1'b0, -10, -10);
    endtask

    task automatic test_ignore_start();
        start_frame("busy_start", 8'h96, CONF_8N1, 1'b0);
        monitor_frame("busy_start", {6'b0, 1'b1, 8'h96, 1'b0}, 10, 1'b0, 100, -10);
    endtask

    task automatic test_back_to_back();
        start_frame("b2b_first", 8'hC3, CONF_8N1, 1'b1);
        tx_data_i = 8'h3C;
        monitor_frame("b2b_first", {6'b0, 1'b1, 8'hC3, 1'b0}, 10, 1'b1, -10, -10);
        tx_start_i = 1'b0;
        monitor_frame("b2b_second", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, 1'b0, -10, -10);
    endtask

    task automatic test_reset_mid_frame();
        int ticks;
        int cyc;
        int bad_done;
        bit prev;
        start_frame("rst_mid", 8'hF0, CONF_8N1, 1'b0);
        ticks = 0; cyc = 0; bad_done = 0;
        while (ticks < 50 && cyc < 1000) begin
            prev = baud_en_i;
            step();
            cyc++;
            if (prev) ticks++;
        end
        rst_ni = 1'b0;
        #1;
        tests++;
        if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_async: line=%b busy=%b, want 1 0", uart_tx_o, tx_busy_o);
        end
        repeat (3) begin
            step();
            if (tx_done_o !== 1'b0) bad_done++;
        end
        rst_ni = 1'b1;
        repeat (2) begin
            step();
            if (tx_done_o !== 1'b0 || uart_tx_o !== 1'b1) bad_done++;
        end
        tests++;
        if (bad_done != 0) begin
            fails++;
            $display("FAIL rst_mid_no_done: %0d bad cycles, want 0", bad_done);
        end
        start_frame("rst_after", 8'h0F, CONF_8N1, 1'b0);
        monitor_frame("rst_after", {6'b0, 1'b1, 8'h0F, 1'b0}, 10, 1'b0, -10, -10);
    endtask

    task automatic test_enable();
        int bad;
        bad = 0;
        tx_en_i = 1'b0;
        tx_start_i = 1'b1;
        repeat (40) begin
            step();
            if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b0) bad++;
        end
        tx_start_i = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL en_low_ignore: %0d cycles not idle, want 0", bad);
        end
        start_frame("en_drop", 8'h55, CONF_8N1, 1'b0);
        monitor_frame("en_drop", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 1'b0, -10, 200);
        bad = 0;
        tx_start_i = 1'b1;
        repeat (20) begin
            step();
            if (uart_tx_o !== 1'b1 || tx_busy_o !== 1'b0) bad++;
        end
        tx_start_i = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL en_drop_no_restart: %0d cycles not idle, want 0", bad);
        end
        tx_en_i = 1'b1;
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_5e2();
        test_7e1();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_frame();
        test_enable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
